s_cpu_irq_ctrl: RTL and testbench

Interrupt conditioning and arbitration stage between the S_CPU_IRQ tile's switch matrix and the CPU's interrupt interface. It consumes the four fabric-routed interrupt lines IRQ0..IRQ3, resynchronises them and applies a per-line polarity and level/edge mode taken from tile configuration bits. It latches edge events as pending and presents one prioritised interrupt at a time to the CPU over a valid/ack handshake.

---
 rtl/s_cpu_irq_ctrl_pkg.sv | 28 ++
 rtl/s_cpu_irq_ctrl_if.sv | 26 ++
 rtl/s_cpu_irq_ctrl_line_cond.sv | 42 ++++
 rtl/s_cpu_irq_ctrl.sv | 83 ++++++++
 tb/tb_s_cpu_irq_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/s_cpu_irq_ctrl_pkg.sv
// Shared types and constants for the S_CPU_IRQ interrupt conditioning stage.
package s_cpu_irq_pkg;

  localparam int unsigned NUM_IRQ  = 4;
  localparam int unsigned ID_W     = 2;
  localparam int unsigned CFG_MODE = 0;
  localparam int unsigned CFG_POL  = 1;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    GAP
  } irq_state_t;

  // Lowest set index wins.
  function automatic logic [ID_W-1:0] prio_enc(input logic [NUM_IRQ-1:0] cand);
    logic found;
    prio_enc = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (cand[i] && !found) begin
        prio_enc = ID_W'(i);
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/s_cpu_irq_ctrl_if.sv
// CPU-facing interrupt handshake: presentation, ack, per-line enable and status.
interface s_cpu_irq_ctrl_if;
  import s_cpu_irq_pkg::*;

  logic [NUM_IRQ-1:0] irq_mask_i;
  logic               irq_ack_i;
  logic               irq_valid_o;
  logic [ID_W-1:0]    irq_id_o;
  logic [NUM_IRQ-1:0] irq_pending_o;

  modport master (
    input  irq_mask_i,
    input  irq_ack_i,
    output irq_valid_o,
    output irq_id_o,
    output irq_pending_o
  );

  modport slave (
    output irq_mask_i,
    output irq_ack_i,
    input  irq_valid_o,
    input  irq_id_o,
    input  irq_pending_o
  );
endinterface

// File: rtl/s_cpu_irq_ctrl_line_cond.sv
// Per-line conditioning: synchroniser, polarity, rising-edge detect and pending flop.
module irq_line_cond #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic mode,
  input  logic pol,
  input  logic clr,
  input  logic warm,
  output logic active
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   pend;
  logic                   act;
  logic                   rise;

  assign act  = sync[SYNC_STAGES-1] ^ pol;
  assign rise = mode & act & ~prev & ~warm;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
      pend <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      prev <= act;
      // A new edge in the ack cycle must not be lost, so set beats clear.
      if (rise)
        pend <= 1'b1;
      else if (clr)
        pend <= 1'b0;
    end
  end

  assign active = mode ? pend : act;

endmodule

// File: rtl/s_cpu_irq_ctrl.sv
// Interrupt conditioning and arbitration between the tile switch matrix and the CPU.
module s_cpu_irq_ctrl #(
  parameter int unsigned NUM_IRQ      = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned NoConfigBits = 8
) (
  input  logic                    UserCLK,
  input  logic                    rst,
  input  logic [NUM_IRQ-1:0]      irq_i,
  input  logic [NoConfigBits-1:0] ConfigBits,
  s_cpu_irq_ctrl_if.master        cpu
);
  import s_cpu_irq_pkg::*;

  irq_state_t         state;
  logic [2:0]         warm_cnt;
  logic               warm;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] candidate;

  assign warm = (warm_cnt != '0);

  always_ff @(posedge UserCLK) begin
    if (rst)
      warm_cnt <= 3'(SYNC_STAGES + 1);
    else if (warm)
      warm_cnt <= warm_cnt - 3'd1;
  end

  always_comb begin
    clr = '0;
    for (int unsigned n = 0; n < NUM_IRQ; n++)
      clr[n] = (state == PRESENT) && cpu.irq_ack_i && (cpu.irq_id_o == ID_W'(n));
  end

  for (genvar n = 0; n < NUM_IRQ; n++) begin : g_line
    irq_line_cond #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_line (
      .clk    (UserCLK),
      .rst    (rst),
      .raw    (irq_i[n]),
      .mode   (ConfigBits[2*n + CFG_MODE]),
      .pol    (ConfigBits[2*n + CFG_POL]),
      .clr    (clr[n]),
      .warm   (warm),
      .active (active[n])
    );
  end

  // Arbitration works from the registered status so it matches irq_pending_o.
  assign candidate = cpu.irq_pending_o & cpu.irq_mask_i;

  always_ff @(posedge UserCLK) begin
    if (rst) begin
      state             <= IDLE;
      cpu.irq_valid_o   <= 1'b0;
      cpu.irq_id_o      <= '0;
      cpu.irq_pending_o <= '0;
    end else begin
      cpu.irq_pending_o <= active;
      case (state)
        IDLE: begin
          if (|candidate) begin
            cpu.irq_id_o    <= prio_enc(candidate);
            cpu.irq_valid_o <= 1'b1;
            state           <= PRESENT;
          end
        end
        PRESENT: begin
          if (cpu.irq_ack_i) begin
            cpu.irq_valid_o <= 1'b0;
            state           <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s_cpu_irq_ctrl.sv
// Scoreboard bench for s_cpu_irq_ctrl: stimulus queues expected presentations, a monitor checks them.
module tb_s_cpu_irq_ctrl;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq = '0;
  logic [7:0] cfg = '0;

  s_cpu_irq_ctrl_if bus ();

  s_cpu_irq_ctrl #(
    .NUM_IRQ     (4),
    .SYNC_STAGES (SYNC),
    .NoConfigBits(8)
  ) dut (
    .UserCLK   (clk),
    .rst       (rst),
    .irq_i     (irq),
    .ConfigBits(cfg),
    .cpu       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int min_c;
    int max_c;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising irq_valid_o is a presentation and must match the queue head.
  initial begin
    logic pv;
    int   cur_id;
    exp_t e;
    pv     = 1'b0;
    cur_id = 0;
    forever begin
      @(negedge clk);
      if (bus.irq_valid_o && !pv) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_present: id %0d at cyc %0d, expected none", bus.irq_id_o, cyc);
        end else begin
          e = q.pop_front();
          if (int'(bus.irq_id_o) != e.id || cyc < e.min_c || cyc > e.max_c) begin
            n_fail++;
            $display("FAIL present: id %0d at cyc %0d, expected id %0d at cyc %0d..%0d",
                     bus.irq_id_o, cyc, e.id, e.min_c, e.max_c);
          end
        end
        cur_id = int'(bus.irq_id_o);
      end else if (bus.irq_valid_o && pv) begin
        check("hold_id", int'(bus.irq_id_o), cur_id);
      end
      pv = bus.irq_valid_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (6) tick();
  endtask

  task automatic push(input int id, input int lo, input int hi);
    exp_t e;
    e.id    = id;
    e.min_c = lo;
    e.max_c = hi;
    q.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    n_chk++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.irq_valid_o) return;
    end
    n_fail++;
    $display("FAIL %s: irq_valid_o got 0 for 20 cycles, expected 1", name);
  endtask

  task automatic ack_once(output int m);
    tick();
    bus.irq_ack_i = 1'b1;
    m = cyc;
    tick();
    bus.irq_ack_i = 1'b0;
  endtask

  task automatic neg_at(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int c;
    int m;
    int k;
    #200000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int m;
    int k;
    bus.irq_mask_i = '0;
    bus.irq_ack_i  = 1'b0;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    check("rst_valid", int'(bus.irq_valid_o), 0);
    check("rst_id", int'(bus.irq_id_o), 0);
    check("rst_pending", int'(bus.irq_pending_o), 0);

    // Level, active-high, line 2
    cfg = 8'h00;
    bus.irq_mask_i = 4'b0100;
    do_reset();
    tick(); irq[2] = 1'b1; c = cyc;
    push(2, c + 4, c + 4);
    wait_valid("lvl_first");
    ack_once(m);
    push(2, m + 3, m + 3);
    wait_valid("lvl_repeat");
    irq[2] = 1'b0;
    repeat (6) tick();
    ack_once(m);
    repeat (8) tick();
    @(negedge clk);
    check("lvl_done_valid", int'(bus.irq_valid_o), 0);
    check("lvl_done_pending", int'(bus.irq_pending_o), 0);

    // Edge on lines 0 and 3 simultaneously
    cfg = 8'h41;
    bus.irq_mask_i = 4'hF;
    do_reset();
    tick(); irq = 4'b1001; c = cyc;
    push(0, c + 5, c + 5);
    tick(); irq = '0;
    neg_at(c + 4);
    check("edge_pend_both", int'(bus.irq_pending_o), 4'b1001);
    wait_valid("edge_l0");
    ack_once(m);
    push(3, m + 3, m + 3);
    neg_at(m + 2);
    check("edge_pend_after_l0", int'(bus.irq_pending_o), 4'b1000);
    wait_valid("edge_l3");
    ack_once(m);
    neg_at(m + 2);
    check("edge_pend_none", int'(bus.irq_pending_o), 4'b0000);

    // Edge line 1 re-pulses in its ack cycle
    cfg = 8'h04;
    do_reset();
    tick(); irq[1] = 1'b1; c = cyc;
    push(1, c + 5, c + 5);
    tick(); irq[1] = 1'b0;
    wait_valid("coll_first");
    tick(); irq[1] = 1'b1; k = cyc;
    tick(); irq[1] = 1'b0;
    tick(); bus.irq_ack_i = 1'b1;
    push(1, k + 5, k + 5);
    tick(); bus.irq_ack_i = 1'b0;
    neg_at(k + 4);
    check("coll_pend_kept", int'(bus.irq_pending_o), 4'b0010);
    wait_valid("coll_repeat");
    ack_once(m);
    neg_at(m + 2);
    check("coll_pend_clear", int'(bus.irq_pending_o), 4'b0000);

    // Active-low level line 1 held low through reset
    cfg = 8'h08;
    bus.irq_mask_i = 4'b0010;
    irq = '0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("al_no_valid_in_rst", int'(bus.irq_valid_o), 0);
    end
    tick(); rst = 1'b0; k = cyc;
    push(1, k + 2, k + SYNC + 2);
    wait_valid("al_present");
    bus.irq_mask_i = '0;
    ack_once(m);
    repeat (4) tick();
    @(negedge clk);
    check("al_done_valid", int'(bus.irq_valid_o), 0);

    // Presentation held through mask clear and source drop
    cfg = 8'h00;
    bus.irq_mask_i = 4'b0100;
    do_reset();
    tick(); irq[2] = 1'b1; c = cyc;
    push(2, c + 4, c + 4);
    wait_valid("hold_present");
    tick(); bus.irq_mask_i = '0; irq[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hold_valid", int'(bus.irq_valid_o), 1);
    end
    ack_once(m);
    repeat (6) tick();
    @(negedge clk);
    check("hold_done_valid", int'(bus.irq_valid_o), 0);

    // Reset while presenting an edge on line 0
    cfg = 8'h01;
    bus.irq_mask_i = 4'hF;
    do_reset();
    tick(); irq[0] = 1'b1; c = cyc;
    push(0, c + 5, c + 5);
    tick(); irq[0] = 1'b0;
    wait_valid("mid_present");
    tick(); rst = 1'b1; k = cyc;
    neg_at(k + 1);
    check("mid_rst_valid", int'(bus.irq_valid_o), 0);
    check("mid_rst_id", int'(bus.irq_id_o), 0);
    check("mid_rst_pending", int'(bus.irq_pending_o), 0);
    tick(); rst = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    check("mid_quiet_valid", int'(bus.irq_valid_o), 0);
    check("mid_quiet_pending", int'(bus.irq_pending_o), 0);
    tick(); irq[0] = 1'b1; c = cyc;
    push(0, c + 5, c + 5);
    tick(); irq[0] = 1'b0;
    wait_valid("mid_new_edge");
    ack_once(m);

    repeat (10) tick();
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
